// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with single-cycle ops, a radix-2 Booth multiplier
// and a non-restoring divider.
//
// Opcode map (op[4:0]):
//   0 LOAD  1 LOAD_IMM  2 STORE  3 ADD  4 ADD_IMM  5 SUB  6 MUL  7 DIV
//   8 SHR   9 SHL  10 ROR  11 ROL  12 AND  13 AND_IMM  14 OR  15 OR_IMM
//   16 NEG  17 NOT  18 SHRA   (anything else: a+b, z_high=0)
//
// Ports:
//   clk, clr_n        clock, asynchronous active-low reset
//   start, op, a, b   request; sampled on a rising edge while busy=0
//   inc_pc            request is z_low=b+1, overriding op
//   busy              an iterative op (MUL/DIV/DIVFIX) is in progress
//   done              one-cycle pulse; z_high/z_low/dbz valid from then on
//   z_high, z_low     registered result pair
//   dbz               divide-by-zero flag
//   state_dbg         current FSM state
//
// Handshake: a request is accepted on a rising edge where start=1 and
// busy=0 (IDLE or DONE). Nothing else is sampled from the request inputs
// after that edge; the result appears in the DONE cycle and is held
// until the DONE cycle of the next accepted request.
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             start,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             inc_pc,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] z_high,
    output logic [WIDTH-1:0] z_low,
    output logic             dbz,
    output logic [2:0]       state_dbg
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [4:0] OP_LOAD = 5'd0,  OP_LOAD_IMM = 5'd1, OP_STORE = 5'd2;
    localparam logic [4:0] OP_ADD  = 5'd3,  OP_ADD_IMM  = 5'd4, OP_SUB   = 5'd5;
    localparam logic [4:0] OP_MUL  = 5'd6,  OP_DIV      = 5'd7, OP_SHR   = 5'd8;
    localparam logic [4:0] OP_SHL  = 5'd9,  OP_ROR      = 5'd10, OP_ROL  = 5'd11;
    localparam logic [4:0] OP_AND  = 5'd12, OP_AND_IMM  = 5'd13, OP_OR   = 5'd14;
    localparam logic [4:0] OP_OR_IMM = 5'd15, OP_NEG = 5'd16, OP_NOT = 5'd17;
    localparam logic [4:0] OP_SHRA = 5'd18;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_MUL    = 3'd1;
    localparam logic [2:0] S_DIV    = 3'd2;
    localparam logic [2:0] S_DIVFIX = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]       state;
    logic [CW-1:0]    cnt;
    // Shared iteration registers:
    //   MUL: acc = Booth accumulator (one guard bit), qr = multiplier, opnd = multiplicand
    //   DIV: acc = partial remainder (signed), qr = dividend/quotient, opnd = |divisor|
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] qr;
    logic [WIDTH-1:0] opnd;
    logic             q1;
    logic             neg_q;
    logic             neg_r;

    logic accept;
    assign accept    = start && ((state == S_IDLE) || (state == S_DONE));
    assign busy      = (state == S_MUL) || (state == S_DIV) || (state == S_DIVFIX);
    assign done      = (state == S_DONE);
    assign state_dbg = state;

    // ---------------- single-cycle results ----------------
    logic [WIDTH:0]     sum_ab, dif_ab;
    logic [2*WIDTH-1:0] ror_v, rol_v;
    logic [SHW-1:0]     sh;
    logic [WIDTH-1:0]   sc_low, sc_high;

    always_comb begin
        sh      = b[SHW-1:0];
        sum_ab  = {1'b0, a} + {1'b0, b};
        dif_ab  = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
        ror_v   = {a, a} >> sh;
        rol_v   = {a, a} << sh;
        sc_low  = sum_ab[WIDTH-1:0];
        sc_high = '0;
        if (inc_pc) begin
            sc_low = b + WIDTH'(1);
        end else begin
            case (op)
                OP_LOAD, OP_LOAD_IMM, OP_STORE, OP_ADD, OP_ADD_IMM: begin
                    sc_low  = sum_ab[WIDTH-1:0];
                    sc_high = {{(WIDTH-1){1'b0}}, sum_ab[WIDTH]};
                end
                OP_SUB: begin
                    sc_low  = dif_ab[WIDTH-1:0];
                    sc_high = {{(WIDTH-1){1'b0}}, dif_ab[WIDTH]};
                end
                OP_SHR:  sc_low = a >> sh;
                OP_SHRA: sc_low = $signed(a) >>> sh;
                OP_SHL:  sc_low = a << sh;
                OP_ROR:  sc_low = ror_v[WIDTH-1:0];
                OP_ROL:  sc_low = rol_v[2*WIDTH-1:WIDTH];
                OP_AND, OP_AND_IMM: sc_low = a & b;
                OP_OR, OP_OR_IMM:   sc_low = a | b;
                OP_NEG:  sc_low = ~a + WIDTH'(1);
                OP_NOT:  sc_low = ~a;
                default: sc_low = sum_ab[WIDTH-1:0];
            endcase
        end
    end

    // ---------------- Booth step ----------------
    // acc carries one guard bit so that subtracting the most-negative
    // multiplicand cannot overflow before the arithmetic shift.
    logic [WIDTH:0]   m_ext, b_sum, b_acc;
    logic [WIDTH-1:0] b_q;

    always_comb begin
        m_ext = {opnd[WIDTH-1], opnd};
        case ({qr[0], q1})
            2'b01:   b_sum = acc + m_ext;
            2'b10:   b_sum = acc - m_ext;
            default: b_sum = acc;
        endcase
        b_acc = {b_sum[WIDTH], b_sum[WIDTH:1]};
        b_q   = {b_sum[0], qr[WIDTH-1:1]};
    end

    // ---------------- non-restoring divide step / fix-up ----------------
    logic [WIDTH:0]   d_shift, d_rem, r_fix;
    logic [WIDTH-1:0] d_q, abs_a, abs_b, q_out, r_out;

    always_comb begin
        abs_a   = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
        abs_b   = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;
        d_shift = {acc[WIDTH-1:0], qr[WIDTH-1]};
        if (acc[WIDTH]) d_rem = d_shift + {1'b0, opnd};
        else            d_rem = d_shift - {1'b0, opnd};
        d_q     = {qr[WIDTH-2:0], ~d_rem[WIDTH]};
        // A negative final remainder is one divisor short.
        r_fix   = acc[WIDTH] ? (acc + {1'b0, opnd}) : acc;
        q_out   = neg_q ? (~qr + WIDTH'(1)) : qr;
        r_out   = neg_r ? (~r_fix[WIDTH-1:0] + WIDTH'(1)) : r_fix[WIDTH-1:0];
    end

    // ---------------- FSM and datapath registers ----------------
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            acc    <= '0;
            qr     <= '0;
            opnd   <= '0;
            q1     <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            z_high <= '0;
            z_low  <= '0;
            dbz    <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        cnt <= '0;
                        acc <= '0;
                        q1  <= 1'b0;
                        if (!inc_pc && op == OP_MUL) begin
                            qr    <= b;
                            opnd  <= a;
                            state <= S_MUL;
                        end else if (!inc_pc && op == OP_DIV && b != '0) begin
                            qr    <= abs_a;
                            opnd  <= abs_b;
                            neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
                            neg_r <= a[WIDTH-1];
                            state <= S_DIV;
                        end else if (!inc_pc && op == OP_DIV) begin
                            z_low  <= '1;
                            z_high <= a;
                            dbz    <= 1'b1;
                            state  <= S_DONE;
                        end else begin
                            z_low  <= sc_low;
                            z_high <= sc_high;
                            dbz    <= 1'b0;
                            state  <= S_DONE;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_MUL: begin
                    acc <= b_acc;
                    qr  <= b_q;
                    q1  <= qr[0];
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH-1)) begin
                        z_high <= b_acc[WIDTH-1:0];
                        z_low  <= b_q;
                        dbz    <= 1'b0;
                        state  <= S_DONE;
                    end
                end
                S_DIV: begin
                    acc <= d_rem;
                    qr  <= d_q;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH-1)) state <= S_DIVFIX;
                end
                S_DIVFIX: begin
                    z_low  <= q_out;
                    z_high <= r_out;
                    dbz    <= 1'b0;
                    state  <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: hand-computed WIDTH=32 vectors, then an
// exhaustive WIDTH=8 MUL/DIV sweep over 256 parallel instances (one per
// value of a) compared against integer arithmetic.
module tb_seq_alu;
  localparam logic [4:0] OP_ADD = 5'd3, OP_SUB = 5'd5, OP_MUL = 5'd6, OP_DIV = 5'd7;
  localparam logic [4:0] OP_SHR = 5'd8, OP_SHL = 5'd9, OP_ROR = 5'd10, OP_ROL = 5'd11;
  localparam logic [4:0] OP_AND = 5'd12, OP_OR = 5'd14, OP_NEG = 5'd16, OP_NOT = 5'd17;
  localparam logic [4:0] OP_SHRA = 5'd18;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic clr_n;
  always #5 clk = ~clk;

  // ---------------- WIDTH=32 DUT ----------------
  logic        start, inc_pc, busy, done, dbz;
  logic [4:0]  op;
  logic [31:0] a, b, z_high, z_low;
  logic [2:0]  state_dbg;

  seq_alu #(.WIDTH(32)) dut (
    .clk(clk), .clr_n(clr_n), .start(start), .op(op), .a(a), .b(b),
    .inc_pc(inc_pc), .busy(busy), .done(done), .z_high(z_high),
    .z_low(z_low), .dbz(dbz), .state_dbg(state_dbg)
  );

  // ---------------- WIDTH=8 DUT array ----------------
  logic       start8, inc8;
  logic [4:0] op8;
  logic [7:0] b8;
  logic       busy8 [256];
  logic       done8 [256];
  logic       dbz8  [256];
  logic [7:0] zh8   [256];
  logic [7:0] zl8   [256];
  logic [2:0] st8   [256];

  for (genvar g = 0; g < 256; g++) begin : g_w8
    seq_alu #(.WIDTH(8)) u8 (
      .clk(clk), .clr_n(clr_n), .start(start8), .op(op8), .a(8'(g)), .b(b8),
      .inc_pc(inc8), .busy(busy8[g]), .done(done8[g]), .z_high(zh8[g]),
      .z_low(zl8[g]), .dbz(dbz8[g]), .state_dbg(st8[g])
    );
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Called just after a falling edge. Raises start, waits for done with a
  // bound, checks latency, busy and that results hold while busy. With
  // noise=1 random requests and operand changes are thrown at the DUT
  // while it is busy; they must be ignored.
  task automatic run32(input string tag, input logic [4:0] o, input logic [31:0] aa,
                       input logic [31:0] bb, input logic ip, input int exp_lat,
                       input bit noise);
    logic [63:0] prev;
    logic        prev_dbz;
    int          lat;
    bit          hold_ok;
    op = o; a = aa; b = bb; inc_pc = ip; start = 1'b1;
    prev = {z_high, z_low};
    prev_dbz = dbz;
    lat = 0;
    hold_ok = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
      if (!busy || {z_high, z_low} !== prev || dbz !== prev_dbz) hold_ok = 1'b0;
      if (noise) begin
        start  = 1'($urandom_range(0, 1));
        op     = 5'($urandom_range(0, 18));
        a      = $urandom;
        b      = $urandom;
        inc_pc = 1'($urandom_range(0, 1));
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    inc_pc = 1'b0;
    chk({tag, ".lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, ".hold"}, 64'(hold_ok), 64'(1));
    chk({tag, ".busy_at_done"}, 64'(busy), 64'(0));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int   lat;
    bit   quiet;
    int   sa, sb, q, r;
    logic [63:0] e8;

    clr_n = 1'b0; start = 1'b0; inc_pc = 1'b0; op = '0; a = '0; b = '0;
    start8 = 1'b0; inc8 = 1'b0; op8 = '0; b8 = '0;

    #3;
    chk("rst.z", {z_high, z_low}, 64'h0);
    chk("rst.flags", 64'({busy, done, dbz, state_dbg}), 64'h0);

    @(negedge clk); @(negedge clk);
    clr_n = 1'b1;  // first start goes out on the very first edge after release
    run32("add_carry", OP_ADD, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 1, 1'b0);
    chk("add_carry.z", {z_high, z_low}, 64'h00000001_00000001);
    @(negedge clk);
    chk("done_fall", 64'({done, busy, state_dbg}), 64'h0);

    run32("sub_neg", OP_SUB, 32'd5, 32'd7, 1'b0, 1, 1'b0);
    chk("sub_neg.z", {z_high, z_low}, 64'h00000000_FFFFFFFE);
    run32("sub_pos", OP_SUB, 32'd7, 32'd5, 1'b0, 1, 1'b0);
    chk("sub_pos.z", {z_high, z_low}, 64'h00000001_00000002);

    run32("mul_neg", OP_MUL, 32'hFFFF_FFFD, 32'h0000_0007, 1'b0, 33, 1'b1);
    chk("mul_neg.z", {z_high, z_low}, 64'hFFFFFFFF_FFFFFFEB);
    chk("mul_neg.dbz", 64'(dbz), 64'h0);
    run32("mul_min", OP_MUL, 32'h8000_0000, 32'h8000_0000, 1'b0, 33, 1'b0);
    chk("mul_min.z", {z_high, z_low}, 64'h40000000_00000000);

    run32("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 34, 1'b1);
    chk("div_neg.z", {z_high, z_low}, 64'hFFFFFFFF_FFFFFFFD);
    run32("div_zero", OP_DIV, 32'd5, 32'd0, 1'b0, 1, 1'b0);
    chk("div_zero.z", {z_high, z_low}, 64'h00000005_FFFFFFFF);
    chk("div_zero.dbz", 64'(dbz), 64'h1);
    run32("add_clr_dbz", OP_ADD, 32'd3, 32'd4, 1'b0, 1, 1'b0);
    chk("add_clr_dbz.z", {z_high, z_low}, 64'h00000000_00000007);
    chk("add_clr_dbz.dbz", 64'(dbz), 64'h0);
    run32("div_min", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 34, 1'b0);
    chk("div_min.z", {z_high, z_low}, 64'h00000000_80000000);
    chk("div_min.dbz", 64'(dbz), 64'h0);
    run32("div_negb", OP_DIV, 32'd100, 32'hFFFF_FFF9, 1'b0, 34, 1'b0);
    chk("div_negb.z", {z_high, z_low}, 64'h00000002_FFFFFFF2);

    run32("shra", OP_SHRA, 32'h8000_0000, 32'h0000_0024, 1'b0, 1, 1'b0);
    chk("shra.z", {z_high, z_low}, 64'h00000000_F8000000);
    run32("rol", OP_ROL, 32'h8000_0001, 32'h0000_0001, 1'b0, 1, 1'b0);
    chk("rol.z", {z_high, z_low}, 64'h00000000_00000003);
    run32("ror", OP_ROR, 32'h0000_0001, 32'h0000_0004, 1'b0, 1, 1'b0);
    chk("ror.z", {z_high, z_low}, 64'h00000000_10000000);
    run32("shr", OP_SHR, 32'h8000_0000, 32'h0000_0004, 1'b0, 1, 1'b0);
    chk("shr.z", {z_high, z_low}, 64'h00000000_08000000);
    run32("shl", OP_SHL, 32'h0000_0001, 32'h0000_001F, 1'b0, 1, 1'b0);
    chk("shl.z", {z_high, z_low}, 64'h00000000_80000000);
    run32("and", OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 1, 1'b0);
    chk("and.z", {z_high, z_low}, 64'h00000000_F000F000);
    run32("or", OP_OR, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 1, 1'b0);
    chk("or.z", {z_high, z_low}, 64'h00000000_FFF0FFF0);
    run32("not", OP_NOT, 32'hF0F0_F0F0, 32'h1234_5678, 1'b0, 1, 1'b0);
    chk("not.z", {z_high, z_low}, 64'h00000000_0F0F0F0F);
    run32("neg", OP_NEG, 32'h0000_0001, 32'h0000_0000, 1'b0, 1, 1'b0);
    chk("neg.z", {z_high, z_low}, 64'h00000000_FFFFFFFF);
    run32("inc_pc", OP_MUL, 32'h1234_5678, 32'h0000_000F, 1'b1, 1, 1'b0);
    chk("inc_pc.z", {z_high, z_low}, 64'h00000000_00000010);
    run32("unknown", 5'b11111, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 1, 1'b0);
    chk("unknown.z", {z_high, z_low}, 64'h00000000_00000001);

    // reset in the middle of a multiply
    op = OP_MUL; a = 32'd3; b = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("mid_mul.busy", 64'(busy), 64'h1);
    #2 clr_n = 1'b0;
    #1;
    chk("mid_rst.z", {z_high, z_low}, 64'h0);
    chk("mid_rst.flags", 64'({busy, done, dbz, state_dbg}), 64'h0);
    quiet = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done || busy) quiet = 1'b0;
    end
    chk("mid_rst.no_done", 64'(quiet), 64'h1);
    clr_n = 1'b1;
    run32("add_after_rst", OP_ADD, 32'd10, 32'd20, 1'b0, 1, 1'b0);
    chk("add_after_rst.z", {z_high, z_low}, 64'h00000000_0000001E);
    @(negedge clk);

    // exhaustive WIDTH=8 MUL and DIV
    for (int opi = 0; opi < 2; opi++) begin
      for (int bi = 0; bi < 256; bi++) begin
        op8 = (opi == 0) ? OP_MUL : OP_DIV;
        b8 = 8'(bi);
        start8 = 1'b1;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
          @(negedge clk);
          start8 = 1'b0;
          if (done8[0]) begin
            lat = k;
            break;
          end
        end
        start8 = 1'b0;
        chk((opi == 0) ? "w8_mul.lat" : "w8_div.lat", 64'(lat),
            64'((opi == 0) ? 9 : ((bi == 0) ? 1 : 10)));
        sb = int'($signed(8'(bi)));
        for (int ai = 0; ai < 256; ai++) begin
          sa = int'($signed(8'(ai)));
          if (opi == 0) begin
            e8 = 64'({1'b0, 16'(sa * sb)});
          end else if (sb == 0) begin
            e8 = 64'({1'b1, 8'(ai), 8'hFF});
          end else begin
            q = sa / sb;
            r = sa % sb;
            e8 = 64'({1'b0, 8'(r), 8'(q)});
          end
          chk((opi == 0) ? "w8_mul" : "w8_div",
              64'({dbz8[ai], zh8[ai], zl8[ai]}) | (64'(ai) << 32) | (64'(bi) << 40),
              e8 | (64'(ai) << 32) | (64'(bi) << 40));
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
